// File: rtl/mips_defs.sv
// mips_defs: shared branch/jump class encodings, comparator flag indices and reset PC
package mips_defs;
   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BGEZ = 3'd3;
   localparam logic [2:0] BR_BLTZ = 3'd4;
   localparam logic [2:0] BR_BGTZ = 3'd5;
   localparam logic [2:0] BR_BLEZ = 3'd6;
   localparam logic [2:0] BR_RSVD = 3'd7;
   localparam logic [1:0] JMP_NONE = 2'd0;
   localparam logic [1:0] JMP_J    = 2'd1;
   localparam logic [1:0] JMP_JR   = 2'd2;
   localparam logic [1:0] JMP_RSVD = 2'd3;
   localparam int CMP_EQ  = 0;
   localparam int CMP_GEZ = 1;
   localparam int CMP_EZ  = 2;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/br_cond.sv
// br_cond: decodes branch class against D-stage comparator flags into a taken bit
module br_cond
   import mips_defs::*;
(
   input  logic [2:0] br_type,
   input  logic [2:0] cmp_flags,
   output logic       taken
);
   logic eq, ge, z;
   assign eq = cmp_flags[CMP_EQ];
   assign ge = cmp_flags[CMP_GEZ];
   assign z  = cmp_flags[CMP_EZ];
   // reserved and none classes fall through to not-taken
   always_comb begin
      taken = 1'b0;
      taken = (br_type == BR_BEQ)  ? eq :
              (br_type == BR_BNE)  ? !eq :
              (br_type == BR_BGEZ) ? ge :
              (br_type == BR_BLTZ) ? !ge :
              (br_type == BR_BGTZ) ? (ge && !z) :
              (br_type == BR_BLEZ) ? (!ge || z) : 1'b0;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: F/D program counters, next-PC selection with delay slot, branch statistics
module pc_sequencer
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       br_type,
   input  logic [1:0]       jmp_type,
   input  logic [2:0]       cmp_flags,
   input  logic [15:0]      imm16,
   input  logic [25:0]      instr_index,
   input  logic [31:0]      jr_target,
   output logic [31:0]      pc_f,
   output logic [31:0]      pc_d,
   output logic [31:0]      link_addr,
   output logic [31:0]      npc,
   output logic             redirect,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] br_taken_cnt
);
   logic        condTaken, jmpValid, isBranch, brTaken, countBr;
   logic [31:0] pcPlus4, brTarget, jTarget;
   br_cond uCond (
      .br_type  (br_type),
      .cmp_flags(cmp_flags),
      .taken    (condTaken)
   );
   assign pcPlus4   = pc_f + 32'd4;
   assign brTarget  = pc_f + {{14{imm16[15]}}, imm16, 2'b00};
   assign jTarget   = {pc_f[31:28], instr_index, 2'b00};
   assign link_addr = pc_d + 32'd8;
   // jump outranks any branch; an illegal jump+branch decode never counts the branch
   always_comb begin
      jmpValid = (jmp_type == JMP_J) || (jmp_type == JMP_JR);
      isBranch = (br_type != BR_NONE) && (br_type != BR_RSVD) && !jmpValid;
      brTaken  = isBranch && condTaken;
      redirect = jmpValid || brTaken;
      countBr  = isBranch && !stall;
      npc      = (jmp_type == JMP_J)  ? jTarget :
                 (jmp_type == JMP_JR) ? jr_target :
                 brTaken              ? brTarget : pcPlus4;
   end
   // PC pipeline advances only on free edges; reset overrides stall
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f <= RESET_PC;
         pc_d <= 32'd0;
      end else if (!stall) begin
         pc_f <= npc;
         pc_d <= pc_f;
      end
   end
   // saturating statistics, sampled with whatever flags are present on the committing edge
   always_ff @(posedge clk) begin
      if (reset) begin
         br_cnt       <= '0;
         br_taken_cnt <= '0;
      end else begin
         if (countBr && br_cnt != {CNT_W{1'b1}}) br_cnt <= br_cnt + 1'b1;
         if (countBr && brTaken && br_taken_cnt != {CNT_W{1'b1}}) br_taken_cnt <= br_taken_cnt + 1'b1;
      end
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program counter and next-PC sequencer for the five-stage MIPS pipeline. Consumes the decode-stage branch/jump class and the three comparator flags produced in D (equal, A≥0, A==0). Holds the F-stage and D-stage PC registers and computes the redirect target with architectural delay-slot semantics. Keeps saturating branch statistics for the bench and for debug readout.

## Interface
- RESET_PC, 32'h0000_3000, value loaded into pc_f on reset
- CNT_W, 16, width of the statistics counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  1 = hold F and D PC registers and counters
- br_type  in  3  D-stage branch class: 0 none, 1 beq, 2 bne, 3 bgez, 4 bltz, 5 bgtz, 6 blez, 7 reserved
- jmp_type  in  2  D-stage jump class: 0 none, 1 j/jal, 2 jr/jalr, 3 reserved
- cmp_flags  in  3  bit0 A==B, bit1 A≥0 (A[31]==0), bit2 A==0
- imm16  in  16  D-stage branch offset (word units, signed)
- instr_index  in  26  D-stage j/jal index
- jr_target  in  32  forwarded rs value for jr/jalr
- pc_f  out  32  current fetch address (registered)
- pc_d  out  32  PC of instruction in D (registered)
- link_addr  out  32  pc_d + 8, for jal/jalr write-back
- npc  out  32  next fetch address (combinational)
- redirect  out  1  1 when npc is a taken branch/jump target (combinational)
- br_cnt  out  CNT_W  executed conditional branches (registered)
- br_taken_cnt  out  CNT_W  taken conditional branches (registered)

## Operation
- Branch condition: beq eq; bne !eq; bgez ge0; bltz !ge0; bgtz ge0 & !z; blez !ge0 | z; types 0 and 7 never taken.
- Branch target = pc_f + sign_extend({imm16, 2'b00}). pc_f already equals pc_d+4 (delay-slot address). Arithmetic is 32-bit modulo; wrap past 0xFFFF_FFFC is silent.
- j target = {pc_f[31:28], instr_index, 2'b00}. jr target = jr_target, used as-is with no alignment check.
- Priority: jump (jmp_type 1/2) > taken branch > pc_f+4. Both a jump and a branch asserted is an illegal decode; the jump wins and br_cnt does not count.
- redirect = jump valid or branch taken. npc = the selected target, else pc_f+4.
- Delay slot: the instruction at pc_f is always fetched and executed. No flush output exists.
- Counters: on a non-stalled cycle with br_type in 1..6 and no jump, br_cnt increments; br_taken_cnt also increments when the branch is taken. Both saturate at all-ones and do not wrap.

## Timing
- Reset (synchronous, overrides stall): pc_f=RESET_PC, pc_d=0, br_cnt=0, br_taken_cnt=0. link_addr then reads 8. npc/redirect follow their inputs immediately.
- Non-stalled edge: pc_f←npc, pc_d←pc_f, counters update per the rules above.
- Stalled edge: pc_f, pc_d and counters hold. npc/redirect are still driven combinationally but are not committed.
- Branch latency: a branch resolved in D during cycle n fetches its target at cycle n+1. The delay slot is fetched in cycle n, giving zero bubbles.
- A stall spanning a branch: evaluation repeats every cycle with current cmp_flags. Only the value on the first non-stalled edge commits and counts, so forwarding updates during the stall are honoured.
- Reset asserted mid-stall or mid-branch: reset wins on that edge with no partial commit.

## Structure
- Shared package (mips_defs): BR_NONE..BR_BLEZ, JMP_NONE/JMP_J/JMP_JR encodings, CMP_EQ/CMP_GEZ/CMP_EZ flag bit indices, default RESET_PC.
- One sub-module, br_cond, holds the combinational br_type × cmp_flags → taken decode. It is reused by the bench's reference model.
- PC registers, next-PC mux and counters live in pc_sequencer.

## Test plan
- Reset then 3 unstalled cycles, no branches → pc_f 0x3000, 0x3004, 0x3008, 0x300C; pc_d trails by one; link_addr = pc_d+8.
- pc_f=0x3010, beq, flags=3'b001, imm16=0xFFFC → redirect=1, npc=0x3000, next pc_f=0x3000; br_cnt=1, br_taken_cnt=1.
- bgtz with flags=3'b110 (A==0) → not taken, npc=pc_f+4; bltz with flags=3'b000 → taken.
- j with pc_f=0x3040, instr_index=0x0000C10 → npc=0x0000_3040. jr with jr_target=0x0000_3100 while br_type=1 also set → npc=0x3100, br_cnt unchanged.
- Stall 3 cycles with beq, flags flipping 000→001 during the stall → pc_f held. Commits once, taken, on the first free edge; br_cnt +1 only.
- Preload counters to 0xFFFF via repeated taken branches, then issue one more → both stay 0xFFFF. Assert reset with stall=1 → all registers take their reset values.
